branch_predictor: RTL and testbench

//  Direction predictor and mispredict resolver around the branch evaluator.

---
 rtl/branch_pkg.sv | 24 ++
 rtl/bht_table.sv | 40 ++++
 rtl/branch_predictor.sv | 87 ++++++++
 tb/tb_branch_predictor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch types: condition codes, 2-bit counter type and saturating helpers.
package branch_pkg;

  typedef enum logic [1:0] {
    NE   = 2'b00,
    ALU  = 2'b01,
    NALU = 2'b10,
    AL   = 2'b11
  } branch_cond_t;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CtrMax = 2'b11;
  localparam ctr2_t CtrMin = 2'b00;

  function automatic ctr2_t sat_inc(input ctr2_t c);
    return (c == CtrMax) ? CtrMax : c + 2'd1;
  endfunction

  function automatic ctr2_t sat_dec(input ctr2_t c);
    return (c == CtrMin) ? CtrMin : c - 2'd1;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2^IndexBits 2-bit counters, two async read ports,
// one synchronous write port, synchronous reset to ResetCtr.
module bht_table
  import branch_pkg::*;
#(
  parameter int unsigned IndexBits = 6,
  parameter ctr2_t       ResetCtr  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IndexBits-1:0] rd_idx,
  output ctr2_t                rd_ctr,
  input  logic [IndexBits-1:0] ex_idx,
  output ctr2_t                ex_ctr,
  input  logic                 wr_en,
  input  ctr2_t                wr_ctr
);

  localparam int unsigned Entries = 2 ** IndexBits;

  ctr2_t table_q [Entries];

  // Reads see the stored value; a same-cycle write becomes visible next cycle.
  always_comb begin
    rd_ctr = table_q[rd_idx];
    ex_ctr = table_q[ex_idx];
  end

  // Counter storage with reset-to-weak and single write port at the EX index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        table_q[i] <= ResetCtr;
      end
    end else if (wr_en) begin
      table_q[ex_idx] <= wr_ctr;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direction predictor: counter table lookup in ID, training and registered
// mispredict/redirect generation from the EX-stage branch outcome.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int unsigned WordSize  = 32,
  parameter int unsigned IndexBits = 6,
  parameter ctr2_t       ResetCtr  = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WordSize-1:0] id_pc,
  output logic                id_pred_taken,
  input  logic                ex_valid,
  input  logic                ex_stall,
  input  logic [1:0]          ex_cond,
  input  logic [WordSize-1:0] ex_pc,
  input  logic [WordSize-1:0] ex_target,
  input  logic                ex_pred_taken,
  input  logic                ex_branch_taken,
  output logic                mispredict,
  output logic [WordSize-1:0] redirect_pc,
  output logic [31:0]         branch_cnt,
  output logic [31:0]         mispred_cnt
);

  logic [IndexBits-1:0] id_idx;
  logic [IndexBits-1:0] ex_idx;
  ctr2_t                id_ctr;
  ctr2_t                ex_ctr;
  ctr2_t                ex_ctr_next;
  branch_cond_t         cond;
  logic                 resolve;
  logic                 wrong;
  logic                 train_taken;
  logic                 unused_pc_bits;

  assign id_idx = id_pc[IndexBits+1:2];
  assign ex_idx = ex_pc[IndexBits+1:2];
  assign cond   = branch_cond_t'(ex_cond);

  assign unused_pc_bits = ^{id_pc[WordSize-1:IndexBits+2], id_pc[1:0]};

  bht_table #(
    .IndexBits (IndexBits),
    .ResetCtr  (ResetCtr)
  ) u_bht (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (id_idx),
    .rd_ctr (id_ctr),
    .ex_idx (ex_idx),
    .ex_ctr (ex_ctr),
    .wr_en  (resolve),
    .wr_ctr (ex_ctr_next)
  );

  assign id_pred_taken = id_ctr[1];

  // Resolve qualification; the ~mispredict term squashes the wrong-path shadow slot.
  always_comb begin
    resolve     = ex_valid & ~ex_stall & ~mispredict & (cond != NE);
    wrong       = ex_pred_taken != ex_branch_taken;
    train_taken = ex_branch_taken | (cond == AL);
    ex_ctr_next = train_taken ? sat_inc(ex_ctr) : sat_dec(ex_ctr);
  end

  // Mispredict pulse, redirect target and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      mispredict <= resolve & wrong;
      if (resolve) begin
        if (branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
        if (wrong) begin
          if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
          redirect_pc <= ex_branch_taken ? ex_target : ex_pc + WordSize'(4);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor with a reference model and scoreboard.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic        ex_valid;
  logic        ex_stall;
  logic [1:0]  ex_cond;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        ex_branch_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_predictor #(
    .WordSize  (32),
    .IndexBits (6),
    .ResetCtr  (2'b01)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_pc           (id_pc),
    .id_pred_taken   (id_pred_taken),
    .ex_valid        (ex_valid),
    .ex_stall        (ex_stall),
    .ex_cond         (ex_cond),
    .ex_pc           (ex_pc),
    .ex_target       (ex_target),
    .ex_pred_taken   (ex_pred_taken),
    .ex_branch_taken (ex_branch_taken),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  localparam logic [1:0] C_NE = 2'b00, C_ALU = 2'b01, C_NALU = 2'b10, C_AL = 2'b11;

  typedef struct {
    logic        mis;
    logic [31:0] rpc;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0]  m_tab [64];
  logic        m_valid = 1'b0;
  logic        m_mis;
  logic [31:0] m_rpc, m_bcnt, m_mcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  // One clock: drive inputs, check ID read, advance model, compare registered outputs.
  task automatic cycle(input logic r, input logic v, input logic s, input logic [1:0] c,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pt,
                       input logic bt, input logic [31:0] ipc);
    exp_t e;
    logic res, wr;
    @(negedge clk);
    rst = r; ex_valid = v; ex_stall = s; ex_cond = c; ex_pc = pc;
    ex_target = tgt; ex_pred_taken = pt; ex_branch_taken = bt; id_pc = ipc;
    #1;
    if (m_valid) check("id_pred", {31'd0, id_pred_taken}, {31'd0, m_tab[idx_of(ipc)][1]});
    if (r) begin
      for (int i = 0; i < 64; i++) m_tab[i] = 2'b01;
      m_mis = 1'b0; m_rpc = '0; m_bcnt = '0; m_mcnt = '0;
      m_valid = 1'b1;
    end else begin
      res = v & ~s & ~m_mis & (c != C_NE);
      wr  = pt != bt;
      m_mis = res & wr;
      if (res) begin
        if (bt || c == C_AL) begin
          if (m_tab[idx_of(pc)] != 2'b11) m_tab[idx_of(pc)] = m_tab[idx_of(pc)] + 2'd1;
        end else begin
          if (m_tab[idx_of(pc)] != 2'b00) m_tab[idx_of(pc)] = m_tab[idx_of(pc)] - 2'd1;
        end
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
        if (wr) begin
          if (m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
          m_rpc = bt ? tgt : pc + 32'd4;
        end
      end
    end
    e.mis = m_mis; e.rpc = m_rpc; e.bcnt = m_bcnt; e.mcnt = m_mcnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("mispredict", {31'd0, mispredict}, {31'd0, e.mis});
      check("redirect_pc", redirect_pc, e.rpc);
      check("branch_cnt", branch_cnt, e.bcnt);
      check("mispred_cnt", mispred_cnt, e.mcnt);
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    cycle(1'b0, 1'b0, 1'b0, C_NE, 32'h0, 32'h0, 1'b0, 1'b0, ipc);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_stall = 1'b0; ex_cond = C_NE; ex_pc = '0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_branch_taken = 1'b0; id_pc = '0;

    // Reset
    cycle(1'b1, 1'b0, 1'b0, C_NE, 0, 0, 0, 0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, C_NE, 0, 0, 0, 0, 32'h40);
    idle(32'h40);
    check("rst_pred40", {31'd0, id_pred_taken}, 32'd0);
    check("rst_mis", {31'd0, mispredict}, 32'd0);
    check("rst_bcnt", branch_cnt, 32'd0);
    idle(32'hFC);

    // Train at 0x40: wrong resolve, shadow squashed, then correct resolve
    cycle(1'b0, 1'b1, 1'b0, C_ALU, 32'h40, 32'h100, 1'b0, 1'b1, 32'h40);
    check("train_pulse", {31'd0, mispredict}, 32'd1);
    check("train_rpc", redirect_pc, 32'h100);
    cycle(1'b0, 1'b1, 1'b0, C_ALU, 32'h40, 32'h100, 1'b0, 1'b1, 32'h40);
    check("shadow_nopulse", {31'd0, mispredict}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, C_ALU, 32'h40, 32'h100, 1'b1, 1'b1, 32'h40);
    idle(32'h40);
    check("train_pred40", {31'd0, id_pred_taken}, 32'd1);
    check("train_bcnt", branch_cnt, 32'd2);

    // Saturation then a single not-taken
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 1'b0, C_ALU, 32'h40, 32'h100, 1'b1, 1'b1, 32'h40);
    cycle(1'b0, 1'b1, 1'b0, C_NALU, 32'h40, 32'h100, 1'b1, 1'b0, 32'h40);
    check("sat_rpc", redirect_pc, 32'h44);
    idle(32'h40);
    check("sat_pred40", {31'd0, id_pred_taken}, 32'd1);

    // Shadow squash: second wrong resolve at 0x90 must not train or count
    cycle(1'b0, 1'b1, 1'b0, C_ALU, 32'h80, 32'h200, 1'b1, 1'b0, 32'h80);
    cycle(1'b0, 1'b1, 1'b0, C_ALU, 32'h90, 32'h300, 1'b0, 1'b1, 32'h90);
    idle(32'h90);
    check("squash_pred90", {31'd0, id_pred_taken}, 32'd0);
    check("squash_mcnt", mispred_cnt, 32'd3);

    // Gating: NE, stalled, invalid
    cycle(1'b0, 1'b1, 1'b0, C_NE,  32'hA0, 32'h400, 1'b1, 1'b1, 32'hA0);
    cycle(1'b0, 1'b1, 1'b1, C_ALU, 32'hA0, 32'h400, 1'b0, 1'b1, 32'hA0);
    cycle(1'b0, 1'b0, 1'b0, C_ALU, 32'hA0, 32'h400, 1'b0, 1'b1, 32'hA0);
    idle(32'hA0);
    check("gate_predA0", {31'd0, id_pred_taken}, 32'd0);

    // AL trains toward taken
    cycle(1'b0, 1'b1, 1'b0, C_AL, 32'hE0, 32'h500, 1'b1, 1'b1, 32'hE0);
    idle(32'hE0);
    check("al_predE0", {31'd0, id_pred_taken}, 32'd1);

    // Reset in the cycle after a wrong resolve drops the pending redirect
    cycle(1'b0, 1'b1, 1'b0, C_ALU, 32'hC0, 32'h600, 1'b0, 1'b1, 32'hC0);
    cycle(1'b1, 1'b1, 1'b0, C_ALU, 32'hC0, 32'h600, 1'b0, 1'b1, 32'hC0);
    check("rst2_mis", {31'd0, mispredict}, 32'd0);
    check("rst2_mcnt", mispred_cnt, 32'd0);
    idle(32'h40);
    check("rst2_pred40", {31'd0, id_pred_taken}, 32'd0);

    // Same-index read/write: old value this cycle, new value next cycle
    cycle(1'b0, 1'b1, 1'b0, C_ALU, 32'hC0, 32'h600, 1'b1, 1'b1, 32'hC0);
    check("rw_new_predC0", {31'd0, id_pred_taken}, 32'd1);
    idle(32'hC0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
